// File: rtl/jk_button_driver.sv
// jk_button_driver: sync + debounce of set/clear buttons into one-cycle
// j/k pulses and debounced levels for a downstream jkff.
//
// Ports:
//   clk        rising-edge clock
//   reset      async active-high reset
//   btn_set    raw set button (async, active-high)
//   btn_clr    raw clear button (async, active-high)
//   j, k       registered one-cycle set/clear requests
//   set_level  debounced level of btn_set
//   clr_level  debounced level of btn_clr
//
// Build option: define JKDRV_AUTO_REPEAT_EN to re-pulse every
// REPEAT_CYCLES clocks while a button stays pressed.
module jk_button_driver #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned REPEAT_CYCLES = 8,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_clr,
  output logic j,
  output logic k,
  output logic set_level,
  output logic clr_level
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam longint unsigned MAX_CNT =
    (DB_CYCLES > REPEAT_CYCLES) ? DB_CYCLES : REPEAT_CYCLES;

  if (DB_CYCLES < 1 || REPEAT_CYCLES < 2 ||
      MAX_CNT >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("jk_button_driver: bad parameter set");
  end

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
`ifdef JKDRV_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0] w_btn;
  logic [1:0] w_pulse;
  logic [1:0] w_level;

  assign w_btn = {btn_clr, btn_set};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             r_meta;
    logic             r_sync;
    logic             r_pulse;
    logic             r_level;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pulse_nxt;
    logic             w_level_nxt;
`ifdef JKDRV_AUTO_REPEAT_EN
    logic [CNT_W-1:0] r_rpt;
    logic [CNT_W-1:0] w_rpt_nxt;
`endif

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
`ifdef JKDRV_AUTO_REPEAT_EN
      w_rpt_nxt   = r_rpt;
`endif
      unique case (r_state)
        RELEASED: begin
          if (r_sync) begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = ONE;
          end
        end
        PRESS_WAIT: begin
          if (!r_sync) begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_MAX) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b1;
`ifdef JKDRV_AUTO_REPEAT_EN
            w_rpt_nxt   = '0;
`endif
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
        PRESSED: begin
          if (!r_sync) begin
            w_state_nxt = RELEASE_WAIT;
            w_cnt_nxt   = ONE;
`ifdef JKDRV_AUTO_REPEAT_EN
            w_rpt_nxt   = '0;
`endif
          end else begin
`ifdef JKDRV_AUTO_REPEAT_EN
            // counter value REPEAT_CYCLES is never stored: wrap and pulse
            if (r_rpt == RPT_LAST) begin
              w_rpt_nxt   = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_rpt_nxt = r_rpt + ONE;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (r_sync) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
`ifdef JKDRV_AUTO_REPEAT_EN
            w_rpt_nxt   = '0;
`endif
          end else if (r_cnt == DB_MAX) begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
      endcase
    end

    // level registered from next state so outputs stay flop-driven
    assign w_level_nxt = (w_state_nxt == PRESSED) ||
                         (w_state_nxt == RELEASE_WAIT);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_meta  <= 1'b0;
        r_sync  <= 1'b0;
        r_state <= RELEASED;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_level <= 1'b0;
`ifdef JKDRV_AUTO_REPEAT_EN
        r_rpt   <= '0;
`endif
      end else begin
        r_meta  <= w_btn[g];
        r_sync  <= r_meta;
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pulse <= w_pulse_nxt;
        r_level <= w_level_nxt;
`ifdef JKDRV_AUTO_REPEAT_EN
        r_rpt   <= w_rpt_nxt;
`endif
      end
    end

    assign w_pulse[g] = r_pulse;
    assign w_level[g] = r_level;
  end

  assign j         = w_pulse[0];
  assign k         = w_pulse[1];
  assign set_level = w_level[0];
  assign clr_level = w_level[1];

endmodule

// File: tb/tb_jk_button_driver.sv
// tb_jk_button_driver: directed + random check of jk_button_driver
// against a run-length debounce model.
module tb_jk_button_driver;

  localparam int DB  = 4;
  localparam int REP = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_set = 1'b0;
  logic btn_clr = 1'b0;
  logic j, k, set_level, clr_level;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  jk_button_driver #(
    .DB_CYCLES(DB), .REPEAT_CYCLES(REP), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_set(btn_set), .btn_clr(btn_clr),
    .j(j), .k(k),
    .set_level(set_level), .clr_level(clr_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic act,
                       input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: each channel sees the button two edges late; the
  // debounced level flips after DB+1 consecutive disagreeing
  // samples, and a rising flip emits a pulse.
  bit m_h1[2], m_h2[2], m_lvl[2], m_pul[2];
  int m_run[2], m_rep[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_h1[c] <= 0; m_h2[c] <= 0; m_lvl[c] <= 0;
        m_pul[c] <= 0; m_run[c] <= 0; m_rep[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit s, l, p;
        int r, q;
        s = m_h2[c]; l = m_lvl[c];
        r = m_run[c]; q = m_rep[c]; p = 0;
        if (s != l) begin
          r++; q = 0;
          if (r == DB + 1) begin
            l = s; r = 0; p = s;
          end
        end else if (r != 0) begin
          r = 0; q = 0;
        end else if (l) begin
`ifdef JKDRV_AUTO_REPEAT_EN
          q++;
          if (q == REP) begin q = 0; p = 1; end
`endif
        end
        m_h2[c] <= m_h1[c];
        m_h1[c] <= (c == 0) ? btn_set : btn_clr;
        m_lvl[c] <= l; m_run[c] <= r;
        m_rep[c] <= q; m_pul[c] <= p;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp j", j, m_pul[0]);
      check("cmp k", k, m_pul[1]);
      check("cmp set_level", set_level, m_lvl[0]);
      check("cmp clr_level", clr_level, m_lvl[1]);
    end
  end

  logic cj[64], ck[64], cs[64], cc[64], mj[64];

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    btn_set = 1'b0; btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst j", j, 1'b0);
    check("rst k", k, 1'b0);
    check("rst set_level", set_level, 1'b0);
    check("rst clr_level", clr_level, 1'b0);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  // drive per-edge profiles (bit e = level before edge e), capture
  task automatic cap(input logic [63:0] ps, input logic [63:0] pc,
                     input int n);
    for (int e = 0; e < n; e++) begin
      btn_set = ps[e]; btn_clr = pc[e];
      @(posedge clk); #1;
      cj[e] = j; ck[e] = k; cs[e] = set_level;
      cc[e] = clr_level; mj[e] = m_pul[0];
      @(negedge clk);
    end
    btn_set = 1'b0; btn_clr = 1'b0;
  endtask

  logic [63:0] ps, pc;
  logic any;
  bit exp;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;

    // T1: hold set from edge 0
    do_reset();
    ps = '0; ps[15:0] = '1; pc = '0;
    cap(ps, pc, 16);
    check("t1 j@5", cj[5], 1'b0);
    check("t1 j@6", cj[6], 1'b1);
    check("t1 j@7", cj[7], 1'b0);
    check("t1 lvl@5", cs[5], 1'b0);
    check("t1 lvl@6", cs[6], 1'b1);
    check("t1 model j@5", mj[5], 1'b0);
    check("t1 model j@6", mj[6], 1'b1);
    any = 1'b0;
    for (int e = 0; e < 16; e++) any |= ck[e];
    check("t1 k never", any, 1'b0);

    // T2: 3-cycle clear glitch
    do_reset();
    ps = '0; pc = '0; pc[2:0] = '1;
    cap(ps, pc, 16);
    any = 1'b0;
    for (int e = 0; e < 16; e++) any |= ck[e] | cc[e];
    check("t2 glitch k/clr_level", any, 1'b0);

    // T3: both buttons together
    do_reset();
    ps = '0; ps[11:0] = '1; pc = ps;
    cap(ps, pc, 12);
    check("t3 j@6", cj[6], 1'b1);
    check("t3 k@6", ck[6], 1'b1);
    check("t3 clr_level@6", cc[6], 1'b1);

    // T4: release bounce then full release at edge 30
    do_reset();
    ps = '0; ps[19:0] = '1; ps[29:22] = '1; pc = '0;
    cap(ps, pc, 44);
    any = 1'b0;
    for (int e = 8; e < 44; e++) any |= cj[e];
    check("t4 no second pulse", any, 1'b0);
    any = 1'b1;
    for (int e = 6; e < 36; e++) any &= cs[e];
    check("t4 level held", any, 1'b1);
    check("t4 lvl@35", cs[35], 1'b1);
    check("t4 lvl@36", cs[36], 1'b0);

    // T5: reset after edge 4, released after edge 5, set held
    do_reset();
    btn_set = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t5 j in rst", j, 1'b0);
    check("t5 k in rst", k, 1'b0);
    check("t5 set_level in rst", set_level, 1'b0);
    check("t5 clr_level in rst", clr_level, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int e = 6; e < 16; e++) begin
      @(posedge clk); #1;
      check($sformatf("t5 j@%0d", e), j, 1'(e == 12));
    end
    @(negedge clk);
    btn_set = 1'b0;

    // T6: hold set for 40 cycles
    do_reset();
    ps = '0; ps[39:0] = '1; pc = '0;
    cap(ps, pc, 48);
    for (int e = 0; e < 48; e++) begin
      exp = (e == 6);
`ifdef JKDRV_AUTO_REPEAT_EN
      exp = (e == 6) || (e == 14) || (e == 22) ||
            (e == 30) || (e == 38);
`endif
      check($sformatf("t6 j@%0d", e), cj[e], exp);
    end

    // random phase: independent hold lengths, occasional reset
    do_reset();
    begin
      int left[2];
      left[0] = 0; left[1] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
          if (left[c] == 0) begin
            left[c] = int'($urandom_range(1, 12));
            if (c == 0) btn_set = 1'($urandom_range(0, 1));
            else btn_clr = 1'($urandom_range(0, 1));
          end
          left[c]--;
        end
        if ($urandom_range(0, 399) == 0) begin
          #2 reset = 1'b1;
          @(negedge clk);
          #2 reset = 1'b0;
        end
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
